// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled 3-sample majority vote,
// optional parity and 1/2 stop bits, valid/ready holding register with overrun detect.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int TICK_DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 sync1, rxs, rxs_d;
    logic [2:0]           state;
    logic [TW-1:0]        tcnt;
    logic [SW-1:0]        s;
    logic [BW-1:0]        bitcnt;
    logic                 stopcnt;
    logic                 v0, v1;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_p, ferr_p;
    logic                 done;

    logic tick, vote_tick, end_tick, vote, par_exp;

    assign tick      = (state != S_IDLE) && (tcnt == TW'(TICK_DIV - 1));
    assign vote_tick = tick && (s == SW'(M + 1));
    assign end_tick  = tick && (s == SW'(OVERSAMPLE - 1));
    // Third sample is the live line value at the deciding tick.
    assign vote      = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    assign par_exp   = (^shreg) ^ (PARITY == 2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1   <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            state   <= S_IDLE;
            tcnt    <= '0;
            s       <= '0;
            bitcnt  <= '0;
            stopcnt <= 1'b0;
            v0      <= 1'b1;
            v1      <= 1'b1;
            shreg   <= '0;
            perr_p  <= 1'b0;
            ferr_p  <= 1'b0;
            done    <= 1'b0;
        end else begin
            sync1 <= uart_rx_i;
            rxs   <= sync1;
            rxs_d <= rxs;
            done  <= 1'b0;

            if (state == S_IDLE) tcnt <= '0;
            else if (tick)       tcnt <= '0;
            else                 tcnt <= tcnt + 1'b1;

            if (state == S_IDLE) s <= '0;
            else if (tick)       s <= (s == SW'(OVERSAMPLE - 1)) ? '0 : s + 1'b1;

            if (tick && s == SW'(M - 1)) v0 <= rxs;
            if (tick && s == SW'(M))     v1 <= rxs;

            case (state)
                S_IDLE: begin
                    // Edge-triggered so a held-low line (break) cannot restart a frame.
                    if (rxs_d && !rxs) begin
                        state  <= S_START;
                        perr_p <= 1'b0;
                        ferr_p <= 1'b0;
                    end
                end
                S_START: begin
                    if (vote_tick && vote) state <= S_IDLE;
                    else if (end_tick) begin
                        state  <= S_DATA;
                        bitcnt <= '0;
                    end
                end
                S_DATA: begin
                    if (vote_tick) shreg[bitcnt] <= vote;
                    if (end_tick) begin
                        if (bitcnt == BW'(DATA_BITS - 1)) begin
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stopcnt <= 1'b0;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (vote_tick && (vote != par_exp)) perr_p <= 1'b1;
                    if (end_tick) begin
                        state   <= S_STOP;
                        stopcnt <= 1'b0;
                    end
                end
                S_STOP: begin
                    // Leave at the last stop-bit vote so the next start edge resyncs early.
                    if (vote_tick) begin
                        if (!vote) ferr_p <= 1'b1;
                        if (stopcnt == 1'(STOP_BITS - 1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end else if (end_tick) begin
                        stopcnt <= stopcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o    <= shreg;
                    parity_err_o <= perr_p;
                    frame_err_o  <= ferr_p;
                    rx_valid_o   <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one bit = 64 clk. Instance 0 is 8N1, instance 1 is
// even parity, instance 2 is odd parity with 2 stop bits; 1 and 2 share a line.
module tb_uart_rx_param;

    localparam int BIT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line0 = 1'b1;
    logic linep = 1'b1;
    logic rdy0 = 1'b1;
    logic rdyp = 1'b1;

    logic [7:0] rd [3];
    logic       rv [3];
    logic       pe [3];
    logic       fe [3];
    logic       ov [3];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(line0), .rx_data_o(rd[0]),
        .rx_valid_o(rv[0]), .rx_ready_i(rdy0), .parity_err_o(pe[0]),
        .frame_err_o(fe[0]), .overrun_o(ov[0]));

    uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(linep), .rx_data_o(rd[1]),
        .rx_valid_o(rv[1]), .rx_ready_i(rdyp), .parity_err_o(pe[1]),
        .frame_err_o(fe[1]), .overrun_o(ov[1]));

    uart_rx_param #(.CLK_FREQ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_o (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(linep), .rx_data_o(rd[2]),
        .rx_valid_o(rv[2]), .rx_ready_i(rdyp), .parity_err_o(pe[2]),
        .frame_err_o(fe[2]), .overrun_o(ov[2]));

    int checks = 0;
    int errors = 0;

    // Per-instance monitor: rising edges of rx_valid_o, high cycles, overrun pulses.
    int         vcnt [3] = '{0, 0, 0};
    int         vhi  [3] = '{0, 0, 0};
    int         ocnt [3] = '{0, 0, 0};
    logic [7:0] cd   [3];
    logic       cpe  [3];
    logic       cfe  [3];
    logic       rv_q [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rv[k]) vhi[k]++;
            if (rv[k] && !rv_q[k]) begin
                vcnt[k]++;
                cd[k]  = rd[k];
                cpe[k] = pe[k];
                cfe[k] = fe[k];
            end
            if (ov[k]) ocnt[k]++;
            rv_q[k] = rv[k];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int ln, input logic v, input int n);
        if (ln == 0) line0 = v;
        else         linep = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ln, input logic [7:0] d, input int use_par,
                        input logic pb, input logic sb);
        drive(ln, 1'b1, 2 * BIT);
        drive(ln, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(ln, d[i], BIT);
        if (use_par != 0) drive(ln, pb, BIT);
        drive(ln, sb, BIT);
        drive(ln, 1'b1, 3 * BIT);
    endtask

    typedef struct {
        int         ln;
        logic [7:0] d;
        int         use_par;
        logic       pb;
        logic       sb;
        logic [7:0] ed;
        logic       epe;
        logic       epo;
        logic       efe;
    } vec_t;

    vec_t tv [7];

    initial begin
        int b0, b1, b2, h0, o0;

        tv[0] = '{0, 8'hA5, 0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tv[1] = '{0, 8'h00, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[2] = '{0, 8'h81, 0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1};
        tv[3] = '{1, 8'h03, 1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1, 8'h03, 1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1, 8'h5A, 1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
        tv[6] = '{1, 8'h80, 1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};

        repeat (5) @(negedge clk);
        chk("reset valid", int'(rv[0]), 0);
        chk("reset data", int'(rd[0]), 0);
        chk("reset perr", int'(pe[0]), 0);
        chk("reset ferr", int'(fe[0]), 0);
        chk("reset overrun", int'(ov[0]), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            b0 = vcnt[0]; b1 = vcnt[1]; b2 = vcnt[2]; h0 = vhi[0];
            send(tv[i].ln, tv[i].d, tv[i].use_par, tv[i].pb, tv[i].sb);
            if (tv[i].ln == 0) begin
                chk($sformatf("v%0d frames", i), vcnt[0] - b0, 1);
                chk($sformatf("v%0d pulse width", i), vhi[0] - h0, 1);
                chk($sformatf("v%0d data", i), int'(cd[0]), int'(tv[i].ed));
                chk($sformatf("v%0d perr", i), int'(cpe[0]), 0);
                chk($sformatf("v%0d ferr", i), int'(cfe[0]), int'(tv[i].efe));
            end else begin
                chk($sformatf("v%0d even frames", i), vcnt[1] - b1, 1);
                chk($sformatf("v%0d even data", i), int'(cd[1]), int'(tv[i].ed));
                chk($sformatf("v%0d even perr", i), int'(cpe[1]), int'(tv[i].epe));
                chk($sformatf("v%0d even ferr", i), int'(cfe[1]), int'(tv[i].efe));
                chk($sformatf("v%0d odd frames", i), vcnt[2] - b2, 1);
                chk($sformatf("v%0d odd data", i), int'(cd[2]), int'(tv[i].ed));
                chk($sformatf("v%0d odd perr", i), int'(cpe[2]), int'(tv[i].epo));
                chk($sformatf("v%0d odd ferr", i), int'(cfe[2]), int'(tv[i].efe));
            end
        end

        // False start: 20 clk low pulse, then a real frame must still decode.
        b0 = vcnt[0];
        drive(0, 1'b1, BIT);
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 200);
        chk("false start frames", vcnt[0] - b0, 0);
        send(0, 8'hC3, 0, 1'b0, 1'b1);
        chk("after false start frames", vcnt[0] - b0, 1);
        chk("after false start data", int'(cd[0]), 8'hC3);

        // One-clock low glitch inside data bit 3 of 0xFF.
        b0 = vcnt[0];
        drive(0, 1'b1, 2 * BIT);
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, 3 * BIT);
        drive(0, 1'b1, 40);
        drive(0, 1'b0, 1);
        drive(0, 1'b1, 23);
        drive(0, 1'b1, 4 * BIT);
        drive(0, 1'b1, BIT);
        drive(0, 1'b1, 3 * BIT);
        chk("glitch frames", vcnt[0] - b0, 1);
        chk("glitch data", int'(cd[0]), 8'hFF);
        chk("glitch ferr", int'(cfe[0]), 0);

        // Stop bit 0 followed by a held-low break, then a clean frame.
        b0 = vcnt[0];
        drive(0, 1'b1, 2 * BIT);
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(0, (8'h3C >> i) & 1'b1, BIT);
        drive(0, 1'b0, BIT);
        drive(0, 1'b0, 300);
        drive(0, 1'b1, 3 * BIT);
        chk("break frames", vcnt[0] - b0, 1);
        chk("break data", int'(cd[0]), 8'h3C);
        chk("break ferr", int'(cfe[0]), 1);
        send(0, 8'h5A, 0, 1'b0, 1'b1);
        chk("post-break frames", vcnt[0] - b0, 2);
        chk("post-break data", int'(cd[0]), 8'h5A);
        chk("post-break ferr", int'(cfe[0]), 0);

        // Overrun: consumer stalled across two frames.
        rdy0 = 1'b0;
        b0 = vcnt[0]; o0 = ocnt[0];
        send(0, 8'h11, 0, 1'b0, 1'b1);
        send(0, 8'h22, 0, 1'b0, 1'b1);
        chk("overrun frames", vcnt[0] - b0, 1);
        chk("overrun held data", int'(rd[0]), 8'h11);
        chk("overrun held valid", int'(rv[0]), 1);
        chk("overrun pulses", ocnt[0] - o0, 1);
        h0 = vhi[0];
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("accept valid drops", int'(rv[0]), 0);
        chk("accept single", vhi[0] - h0, 1);
        chk("accept no new frame", vcnt[0] - b0, 1);

        // Reset in the middle of data bit 4 with a word held.
        send(0, 8'h6B, 0, 1'b0, 1'b1);
        chk("pre-reset valid", int'(rv[0]), 1);
        chk("pre-reset data", int'(rd[0]), 8'h6B);
        drive(0, 1'b1, 2 * BIT);
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(0, (8'h33 >> i) & 1'b1, BIT);
        drive(0, 1'b1, 30);
        rst = 1'b1;
        #1;
        chk("mid reset valid", int'(rv[0]), 0);
        chk("mid reset data", int'(rd[0]), 0);
        chk("mid reset perr", int'(pe[0]), 0);
        chk("mid reset ferr", int'(fe[0]), 0);
        chk("mid reset overrun", int'(ov[0]), 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        rdy0 = 1'b1;
        b0 = vcnt[0]; o0 = ocnt[0];
        drive(0, 1'b1, BIT);
        chk("post reset no frame", vcnt[0] - b0, 0);
        send(0, 8'h77, 0, 1'b0, 1'b1);
        chk("post reset frames", vcnt[0] - b0, 1);
        chk("post reset data", int'(cd[0]), 8'h77);
        chk("post reset ferr", int'(cfe[0]), 0);
        chk("post reset overrun", ocnt[0] - o0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
